// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer for the 16-bit ADD/XOR ALU: handshake intake, 4x16 register file, result port.
// Optional zero_flag output is enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [$clog2(NREGS)-1:0]   in_rd,
  input  logic [$clog2(NREGS)-1:0]   in_rs1,
  input  logic [$clog2(NREGS)-1:0]   in_rs2,
  input  logic [WIDTH-1:0]           in_imm,
  input  logic                       resume,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic                       alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  output logic                       res_valid,
  output logic [WIDTH-1:0]           res_data,
  output logic [$clog2(NREGS)-1:0]   res_rd,
  output logic                       halted
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic                       zero_flag
`endif
);

  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT} state_e;
  typedef enum logic [1:0] {OP_LOADI = 2'b00, OP_ADD = 2'b01, OP_XOR = 2'b10, OP_HALT = 2'b11} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IW-1:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [WIDTH-1:0]  rf_q [NREGS];
  logic [WIDTH-1:0]  rf_d [NREGS];
  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [IW-1:0]     res_rd_q, res_rd_d;
  logic [WIDTH-1:0]  wb_data;

  assign wb_data = (op_q == OP_LOADI) ? imm_q : alu_out;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    rf_d        = rf_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    in_ready    = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = op_e'(in_op);
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          imm_d   = in_imm;
          state_d = (op_e'(in_op) == OP_HALT) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        // Operands come from the pre-write register file, so rs == rd sees the old value.
        alu_a       = rf_q[rs1_q];
        alu_b       = rf_q[rs2_q];
        alu_sel     = op_q[1];
        rf_d[rd_q]  = wb_data;
        res_valid_d = 1'b1;
        res_data_d  = wb_data;
        res_rd_d    = rd_q;
        state_d     = S_IDLE;
      end
      S_HALT: begin
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOADI;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rf_q        <= '{default: '0};
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      rf_q        <= rf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign halted    = (state_q == S_HALT);

`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_flag_q, zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    if (state_q == S_EXEC) zero_flag_d = (wb_data == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_flag_q <= 1'b0;
    else        zero_flag_q <= zero_flag_d;
  end

  assign zero_flag = zero_flag_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus HALT, streaming and mid-EXEC reset sequences.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic        resume;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_sel;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_rd;
  logic        halted;
`ifdef ALU_SEQ_ZFLAG_EN
  logic        zero_flag;
`endif

  int checks = 0;
  int failures = 0;
  int nres = 0;
  int n0;

  always #5 clk = ~clk;

  // Purely combinational ALU the sequencer drives.
  assign alu_out = alu_sel ? (alu_a ^ alu_b) : (alu_a + alu_b);

  always @(negedge clk) if (res_valid === 1'b1) nres++;

  alu_op_sequencer #(.WIDTH(16), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .resume(resume), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .halted(halted)
`ifdef ALU_SEQ_ZFLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic [15:0] ea, eb;
    logic        esel;
    logic [15:0] edata;
    logic        ez;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [15:0] imm);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    wait_ready();
    drive(v.op, v.rd, v.rs1, v.rs2, v.imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_exec_ready", idx), {15'd0, in_ready}, 16'd0);
    chk($sformatf("v%0d_alu_a", idx), alu_a, v.ea);
    chk($sformatf("v%0d_alu_b", idx), alu_b, v.eb);
    chk($sformatf("v%0d_alu_sel", idx), {15'd0, alu_sel}, {15'd0, v.esel});
    chk($sformatf("v%0d_exec_resvalid", idx), {15'd0, res_valid}, 16'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_res_valid", idx), {15'd0, res_valid}, 16'd1);
    chk($sformatf("v%0d_res_data", idx), res_data, v.edata);
    chk($sformatf("v%0d_res_rd", idx), {14'd0, res_rd}, {14'd0, v.rd});
`ifdef ALU_SEQ_ZFLAG_EN
    chk($sformatf("v%0d_zero_flag", idx), {15'd0, zero_flag}, {15'd0, v.ez});
`endif
  endtask

  initial begin
    //          op    rd    rs1   rs2   imm       ea        eb        sel   data      z
    vt[0]  = '{2'd0, 2'd0, 2'd0, 2'd0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0};
    vt[1]  = '{2'd0, 2'd1, 2'd0, 2'd0, 16'h00FF, 16'h1234, 16'h1234, 1'b0, 16'h00FF, 1'b0};
    vt[2]  = '{2'd1, 2'd2, 2'd0, 2'd1, 16'h0000, 16'h1234, 16'h00FF, 1'b0, 16'h1333, 1'b0};
    vt[3]  = '{2'd0, 2'd0, 2'd0, 2'd0, 16'hAAAA, 16'h1234, 16'h1234, 1'b0, 16'hAAAA, 1'b0};
    vt[4]  = '{2'd0, 2'd1, 2'd0, 2'd0, 16'hFFFF, 16'hAAAA, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0};
    vt[5]  = '{2'd2, 2'd3, 2'd0, 2'd1, 16'h0000, 16'hAAAA, 16'hFFFF, 1'b1, 16'h5555, 1'b0};
    vt[6]  = '{2'd0, 2'd2, 2'd0, 2'd0, 16'h0000, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b1};
    vt[7]  = '{2'd1, 2'd0, 2'd3, 2'd2, 16'h0000, 16'h5555, 16'h0000, 1'b0, 16'h5555, 1'b0};
    vt[8]  = '{2'd1, 2'd3, 2'd3, 2'd3, 16'h0000, 16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0};
    vt[9]  = '{2'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'h5555, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
    vt[10] = '{2'd0, 2'd1, 2'd0, 2'd0, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0};
    vt[11] = '{2'd1, 2'd0, 2'd0, 2'd1, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[12] = '{2'd2, 2'd1, 2'd1, 2'd1, 16'h0000, 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1};
    vt[13] = '{2'd1, 2'd2, 2'd3, 2'd1, 16'h0000, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; resume = 1'b0;
    drive(2'd0, 2'd0, 2'd0, 2'd0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_res_data", res_data, 16'h0000);
    chk("rst_res_rd", {14'd0, res_rd}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_sel", {15'd0, alu_sel}, 16'd0);
`ifdef ALU_SEQ_ZFLAG_EN
    chk("rst_zero_flag", {15'd0, zero_flag}, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Streaming: in_valid held high, fields advance only when accepted.
    begin
      logic [1:0]  sop[4]  = '{2'd0, 2'd0, 2'd1, 2'd2};
      logic [1:0]  srd[4]  = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [1:0]  srs1[4] = '{2'd0, 2'd0, 2'd0, 2'd2};
      logic [1:0]  srs2[4] = '{2'd0, 2'd0, 2'd1, 2'd0};
      logic [15:0] simm[4] = '{16'h0011, 16'h0022, 16'h0000, 16'h0000};
      logic [15:0] sexp[4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0022};
      @(posedge clk);
      n0 = nres;
      chk("table_pulse_count", n0[15:0], 16'd14);
      for (int cyc = 0; cyc < 9; cyc++) begin
        @(negedge clk);
        if (cyc < 8) chk($sformatf("s%0d_in_ready", cyc), {15'd0, in_ready}, (cyc % 2 == 0) ? 16'd1 : 16'd0);
        chk($sformatf("s%0d_res_valid", cyc), {15'd0, res_valid},
            (cyc % 2 == 0 && cyc > 0) ? 16'd1 : 16'd0);
        if (cyc % 2 == 0 && cyc > 0) begin
          chk($sformatf("s%0d_res_data", cyc), res_data, sexp[cyc/2-1]);
          chk($sformatf("s%0d_res_rd", cyc), {14'd0, res_rd}, {14'd0, srd[cyc/2-1]});
        end
        if (cyc < 8) begin
          drive(sop[cyc/2], srd[cyc/2], srs1[cyc/2], srs2[cyc/2], simm[cyc/2]);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end

    // HALT with a pending ADD r1=r2+r3 held on the input.
    @(negedge clk);
    drive(2'd3, 2'd0, 2'd0, 2'd0, 16'h0000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("halt_halted", {15'd0, halted}, 16'd1);
    drive(2'd1, 2'd1, 2'd2, 2'd3, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("h%0d_in_ready", k), {15'd0, in_ready}, 16'd0);
      chk($sformatf("h%0d_halted", k), {15'd0, halted}, 16'd1);
      chk($sformatf("h%0d_res_valid", k), {15'd0, res_valid}, 16'd0);
    end
`ifdef ALU_SEQ_ZFLAG_EN
    chk("halt_zero_flag", {15'd0, zero_flag}, 16'd0);
`endif
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_halted", {15'd0, halted}, 16'd0);
    chk("resume_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_halt_alu_a", alu_a, 16'h0033);
    chk("post_halt_alu_b", alu_b, 16'h0022);
    chk("post_halt_alu_sel", {15'd0, alu_sel}, 16'd0);
    @(posedge clk); #1;
    chk("post_halt_res_valid", {15'd0, res_valid}, 16'd1);
    chk("post_halt_res_data", res_data, 16'h0055);
    chk("post_halt_res_rd", {14'd0, res_rd}, 16'd1);

    // Reset during EXEC of ADD r2=r0+r1.
    @(negedge clk);
    drive(2'd1, 2'd2, 2'd0, 2'd1, 16'h0000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_exec_alu_a", alu_a, 16'h0011);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_alu_a", alu_a, 16'h0000);
    chk("arst_alu_b", alu_b, 16'h0000);
    chk("arst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("arst_res_data", res_data, 16'h0000);
    chk("arst_res_rd", {14'd0, res_rd}, 16'd0);
    chk("arst_halted", {15'd0, halted}, 16'd0);
    chk("arst_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_no_pulse", {15'd0, res_valid}, 16'd0);
    chk("pulse_count_seq", (nres - n0), 16'd5);

    begin
      vec_t v = '{2'd1, 2'd3, 2'd2, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
      run_vec(v, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue/writeback stage for the 16-bit ADD/XOR ALU.
- Accepts a stream of small instructions over a valid/ready handshake and holds a 4-entry x 16-bit register file.
- Drives the ALU operands and select, then writes the ALU result back to the register file and reports it on a result port.
- The ALU stays purely combinational; this block owns all state.

Parameters:
- WIDTH, 16, datapath width; must match the ALU operand width.
- NREGS, 4, register file depth; index width is log2(NREGS) = 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  sequencer can accept an instruction.
- in_op  input  2  opcode: 00 LOADI, 01 ADD, 10 XOR, 11 HALT.
- in_rd  input  2  destination register index.
- in_rs1  input  2  source register for ALU operand A.
- in_rs2  input  2  source register for ALU operand B.
- in_imm  input  WIDTH  immediate value for LOADI.
- resume  input  1  leave the HALT state.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_sel  output  1  ALU select: 0 ADD, 1 XOR.
- alu_out  input  WIDTH  ALU result.
- res_valid  output  1  one-cycle pulse: result written.
- res_data  output  WIDTH  written value.
- res_rd  output  2  register written.
- halted  output  1  sequencer in HALT.

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE; all register file entries = 0.
  - Latched instruction fields = 0.
  - res_valid = 0, res_data = 0, res_rd = 0, halted = 0.
  - alu_a = 0, alu_b = 0, alu_sel = 0.
- States: IDLE, EXEC, HALT.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at a clock edge, latch op/rd/rs1/rs2/imm.
  - Op 11 (HALT) goes to HALT; any other op goes to EXEC.
  - in_valid low: stay in IDLE.
- EXEC (exactly one cycle, in_ready = 0):
  - alu_a = rf[rs1], alu_b = rf[rs2], alu_sel = op[1] (ADD gives 0, XOR gives 1). These are combinational from the latched fields and the register file.
  - At the closing edge:
    - rf[rd] <= alu_out for ADD/XOR, or in_imm (latched) for LOADI.
    - res_valid <= 1, res_data <= the written value, res_rd <= rd.
    - State goes to IDLE.
- Outside EXEC, alu_a/alu_b/alu_sel = 0.
- res_valid is high for exactly the one cycle following EXEC. res_data/res_rd hold their last value otherwise.
- Throughput: one instruction per 2 cycles. Latency from accept edge to result visible: 2 edges.
- Arithmetic: the ALU wraps modulo 2^WIDTH, with no carry out. The sequencer writes the value unchanged (0xFFFF + 0x0001 gives 0x0000).
- Same-register operands: rs1 = rs2 = rd is legal. Operands are read before the write-back edge, so the old value is used.
- Back-to-back dependency: the next instruction's EXEC reads the written value. No hazard, since write-back completes before the next EXEC.
- HALT:
  - in_ready = 0, halted = 1, no register file writes, no res_valid.
  - resume high at an edge returns to IDLE and clears halted.
  - resume is ignored outside HALT.
- in_valid held high with in_ready low: the instruction is not consumed; the upstream must hold it stable.
- Reset mid-EXEC: the write is lost, the register file clears, and res_valid stays 0.

Optional Feature:
- Macro: ALU_SEQ_ZFLAG_EN.
- When defined:
  - Adds an output port zero_flag (1 bit).
  - Reset value 0.
  - Updated at every write-back edge to (written value == 0). It holds otherwise, including across HALT.
- When undefined:
  - The port is absent and no flag logic is present.
  - All other behaviour is identical.

Test Plan:
- Reset, then LOADI r0=0x1234, LOADI r1=0x00FF, ADD r2=r0+r1 -> res_valid pulses 3 times; final res_data=0x1333, res_rd=2; alu_a=0x1234, alu_b=0x00FF, alu_sel=0 during ADD EXEC.
- XOR r3=r0^r1 with r0=0xAAAA, r1=0xFFFF -> alu_sel=1 in EXEC; res_data=0x5555; rf[3]=0x5555 (check via a later ADD r0=r3+r_zero).
- Wrap: LOADI r0=0xFFFF, LOADI r1=0x0001, ADD r0=r0+r1 -> res_data=0x0000; zero_flag=1 when ALU_SEQ_ZFLAG_EN is defined.
- Continuous in_valid with 4 instructions -> in_ready alternates 1/0; exactly one accept per 2 cycles; no instruction lost or duplicated.
- HALT accepted, then in_valid held with an ADD for 5 cycles -> in_ready=0, halted=1, no res_valid; pulse resume -> IDLE, the ADD is accepted next cycle and its result is correct.
- Assert rst_n low during an EXEC of ADD r2 -> no res_valid; rf[2]=0 afterward; all outputs return to reset values immediately (asynchronous).
